// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in serial-out stage. Accepts one WIDTH-bit word via a valid/ready
//   handshake, then shifts it out one bit per shift_en edge. It also produces a
//   serial valid flag and a registered one-cycle done pulse after the last bit.
//
// Optional feature macro: PISO_PARITY_EN
//   When defined, an even-parity bit is appended after the data bits.
//   The frame becomes WIDTH+1 bits long.
//
// Parameters:
//   WIDTH      data word width (>= 2)
//   LSB_FIRST  1 = bit 0 transmitted first, 0 = bit WIDTH-1 transmitted first
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   load_valid  upstream offers a word on par_in
//   load_ready  block can accept a word (IDLE)
//   par_in      parallel word, sampled only on a load handshake
//   shift_en    downstream consumes the current bit at this edge
//   ser_out     current serial bit
//   ser_valid   ser_out holds a valid bit
//   busy        a word is in flight
//   done        one-cycle pulse after the final bit is consumed
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] par_in,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;

  // Even parity: the appended bit makes the total count of ones even.
  function automatic logic f_even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sr, w_sr_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] w_sr_shifted;
`ifdef PISO_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  // Shift toward the output end with zero fill.
  always_comb begin
    if (LSB_FIRST) begin
      w_sr_shifted = {1'b0, r_sr[WIDTH-1:1]};
    end else begin
      w_sr_shifted = {r_sr[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state logic for FSM, shift register, counter and done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
`ifdef PISO_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (load_valid) begin
          w_sr_nxt    = par_in;
          w_cnt_nxt   = {CW{1'b0}};
          w_state_nxt = S_SHIFT;
`ifdef PISO_PARITY_EN
          w_par_nxt   = f_even_parity(par_in);
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (shift_en) begin
          w_sr_nxt = w_sr_shifted;
          // Exit on the last bit instead of wrapping the counter.
          if (r_cnt == LAST_CNT) begin
            w_cnt_nxt   = {CW{1'b0}};
`ifdef PISO_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        if (shift_en) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_sr_nxt    = {WIDTH{1'b0}};
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= {WIDTH{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
`ifdef PISO_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // Output decode, purely from registered state.
  always_comb begin
    load_ready = (r_state == S_IDLE);
    busy       = ~load_ready;
    ser_valid  = busy;
    done       = r_done;
    case (r_state)
      S_SHIFT:  ser_out = LSB_FIRST ? r_sr[0] : r_sr[WIDTH-1];
`ifdef PISO_PARITY_EN
      S_PARITY: ser_out = r_par;
`endif
      default:  ser_out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Directed bench for piso_serializer (WIDTH=4). Instance a is built with
//   LSB_FIRST=1 and instance b with LSB_FIRST=0. Table-driven words are sent
//   back to back, with each load issued in the previous word's done cycle.
//   Hand-written sequences cover stalls, ignored loads while busy, and reset in
//   the middle of a word. Honors PISO_PARITY_EN for the appended parity bit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pin;
  logic       sh;
  logic       a_lv, b_lv;
  logic       a_rdy, a_ser, a_val, a_busy, a_done;
  logic       b_rdy, b_ser, b_val, b_busy, b_done;

  logic       cur;
  logic       o_rdy, o_ser, o_val, o_busy, o_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       sel;   // 0 = LSB-first instance, 1 = MSB-first instance
    logic [3:0] par;   // word loaded
    logic [3:0] seq;   // expected serial bits, seq[3] transmitted first
    logic       p;     // expected even-parity bit
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .load_valid(a_lv), .load_ready(a_rdy), .par_in(pin),
    .shift_en(sh), .ser_out(a_ser), .ser_valid(a_val), .busy(a_busy), .done(a_done)
  );

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .load_valid(b_lv), .load_ready(b_rdy), .par_in(pin),
    .shift_en(sh), .ser_out(b_ser), .ser_valid(b_val), .busy(b_busy), .done(b_done)
  );

  // Route the currently selected instance to the observation signals.
  always_comb begin
    o_rdy  = cur ? b_rdy  : a_rdy;
    o_ser  = cur ? b_ser  : a_ser;
    o_val  = cur ? b_val  : a_val;
    o_busy = cur ? b_busy : a_busy;
    o_done = cur ? b_done : a_done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Load a word, shift continuously and check every cycle. The task returns
  // in the done cycle, so a following call loads back to back.
  task automatic run_word(input logic s, input logic [3:0] par, input logic [3:0] seq,
                          input logic p, input string tag);
    cur  = s;
    pin  = par;
    a_lv = ~s;
    b_lv = s;
    sh   = 1'b1;
    step();
    a_lv = 1'b0;
    b_lv = 1'b0;
    pin  = 4'b0000;
    chk({tag, " load_ready low after load"}, o_rdy, 1'b0);
    chk({tag, " busy after load"}, o_busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s bit%0d", tag, k), o_ser, seq[3-k]);
      chk($sformatf("%s ser_valid bit%0d", tag, k), o_val, 1'b1);
      chk($sformatf("%s no done bit%0d", tag, k), o_done, 1'b0);
      step();
    end
`ifdef PISO_PARITY_EN
    chk({tag, " parity bit"}, o_ser, p);
    chk({tag, " parity ser_valid"}, o_val, 1'b1);
    chk({tag, " no done in parity"}, o_done, 1'b0);
    step();
`endif
    chk({tag, " done pulse"}, o_done, 1'b1);
    chk({tag, " load_ready in done cycle"}, o_rdy, 1'b1);
    chk({tag, " ser_valid low in done cycle"}, o_val, 1'b0);
    chk({tag, " ser_out low in idle"}, o_ser, 1'b0);
  endtask

  initial begin
    vecs[0] = '{sel: 1'b0, par: 4'b1011, seq: 4'b1101, p: 1'b1};
    vecs[1] = '{sel: 1'b1, par: 4'b1011, seq: 4'b1011, p: 1'b1};
    vecs[2] = '{sel: 1'b0, par: 4'b0101, seq: 4'b1010, p: 1'b0};
    vecs[3] = '{sel: 1'b1, par: 4'b0001, seq: 4'b0001, p: 1'b1};
    vecs[4] = '{sel: 1'b0, par: 4'b1000, seq: 4'b0001, p: 1'b1};
    vecs[5] = '{sel: 1'b1, par: 4'b1100, seq: 4'b1100, p: 1'b0};
    vecs[6] = '{sel: 1'b0, par: 4'b0110, seq: 4'b0110, p: 1'b0};

    rst  = 1'b1;
    pin  = 4'b0000;
    sh   = 1'b0;
    a_lv = 1'b0;
    b_lv = 1'b0;
    cur  = 1'b0;
    step();
    step();
    chk("reset a load_ready", a_rdy, 1'b1);
    chk("reset a ser_out", a_ser, 1'b0);
    chk("reset a ser_valid", a_val, 1'b0);
    chk("reset a busy", a_busy, 1'b0);
    chk("reset a done", a_done, 1'b0);
    chk("reset b load_ready", b_rdy, 1'b1);
    chk("reset b ser_valid", b_val, 1'b0);
    rst = 1'b0;
    step();

    // Table-driven words, loaded back to back in each done cycle.
    for (int i = 0; i < 7; i++) begin
      run_word(vecs[i].sel, vecs[i].par, vecs[i].seq, vecs[i].p, $sformatf("vec%0d", i));
    end
    step();
    step();

    // Stall: shift_en low for three edges after the first bit.
    cur  = 1'b0;
    pin  = 4'b0110;
    a_lv = 1'b1;
    sh   = 1'b1;
    step();
    a_lv = 1'b0;
    chk("stall bit0", o_ser, 1'b0);
    sh = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall hold %0d", k), o_ser, 1'b0);
      chk($sformatf("stall valid %0d", k), o_val, 1'b1);
      chk($sformatf("stall no done %0d", k), o_done, 1'b0);
    end
    sh = 1'b1;
    step();
    chk("stall bit1", o_ser, 1'b1);
    step();
    chk("stall bit2", o_ser, 1'b1);
    step();
    chk("stall bit3", o_ser, 1'b0);
    chk("stall no early done", o_done, 1'b0);
    step();
`ifdef PISO_PARITY_EN
    chk("stall parity", o_ser, 1'b0);
    chk("stall no done at parity", o_done, 1'b0);
    step();
`endif
    chk("stall done", o_done, 1'b1);
    step();
    chk("stall single done", o_done, 1'b0);

    // A load offered while busy must be ignored.
    pin  = 4'b0001;
    a_lv = 1'b1;
    step();
    pin = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ign ready low %0d", k), o_rdy, 1'b0);
      chk($sformatf("ign bit%0d", k), o_ser, (k == 0) ? 1'b1 : 1'b0);
      if (k == 3) a_lv = 1'b0;
      step();
    end
`ifdef PISO_PARITY_EN
    chk("ign parity", o_ser, 1'b1);
    step();
`endif
    chk("ign done", o_done, 1'b1);
    step();
    chk("ign no reload", o_val, 1'b0);
    chk("ign idle ready", o_rdy, 1'b1);

    // Reset after two bits have been consumed aborts the word at once.
    pin  = 4'b1011;
    a_lv = 1'b1;
    step();
    a_lv = 1'b0;
    chk("abort bit0", o_ser, 1'b1);
    step();
    chk("abort bit1", o_ser, 1'b1);
    step();
    chk("abort bit2 before rst", o_ser, 1'b0);
    chk("abort busy before rst", o_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort ser_out", o_ser, 1'b0);
    chk("abort ser_valid", o_val, 1'b0);
    chk("abort busy", o_busy, 1'b0);
    chk("abort load_ready", o_rdy, 1'b1);
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("abort no done %0d", k), o_done, 1'b0);
    end
    run_word(1'b0, 4'b1001, 4'b1001, 1'b0, "after_abort");
    step();
    chk("final done cleared", o_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a hung simulation.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
